// File: rtl/pb_pkg.sv
// Shared types and counter widths for the pushbutton conditioner.
package pb_pkg;

  localparam int unsigned DB_W  = 16;
  localparam int unsigned RPT_W = 24;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRESS  = 2'd1,
    REPEAT = 2'd2
  } pb_state_e;

endpackage

// File: rtl/pb_channel.sv
// One pushbutton: 2-flop synchroniser, debounce, press FSM and optional auto-repeat.
// Auto-repeat logic is built only when AUTO_REPEAT_EN is defined.
module pb_channel
  import pb_pkg::*;
#(
  parameter logic [DB_W-1:0]  DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [RPT_W-1:0] REPEAT_DELAY    = 24'd5000000,
  parameter logic [RPT_W-1:0] REPEAT_RATE     = 24'd1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic pulse_o
);

  logic [1:0]      sync_q;
  logic [DB_W-1:0] db_cnt_q;
  logic            level_q;
  pb_state_e       state_q;
  logic            pulse_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      db_cnt_q <= '0;
      level_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      if (sync_q[1] != level_q) begin
        if (db_cnt_q == DEBOUNCE_CYCLES - DB_W'(1)) begin
          level_q  <= ~level_q;
          db_cnt_q <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + DB_W'(1);
        end
      end else begin
        db_cnt_q <= '0;
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  // One counter serves as hold counter in PRESS and rate counter in REPEAT.
  logic [RPT_W-1:0] rpt_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pulse_q   <= 1'b0;
      rpt_cnt_q <= '0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (level_q) begin
            state_q   <= PRESS;
            pulse_q   <= 1'b1;
            rpt_cnt_q <= '0;
          end
        end
        PRESS: begin
          if (!level_q) begin
            state_q <= IDLE;
          end else if (rpt_cnt_q == REPEAT_DELAY - RPT_W'(1)) begin
            state_q   <= REPEAT;
            pulse_q   <= 1'b1;
            rpt_cnt_q <= '0;
          end else if (rpt_cnt_q != '1) begin
            rpt_cnt_q <= rpt_cnt_q + RPT_W'(1);
          end
        end
        REPEAT: begin
          if (!level_q) begin
            state_q <= IDLE;
          end else if (rpt_cnt_q == REPEAT_RATE - RPT_W'(1)) begin
            pulse_q   <= 1'b1;
            rpt_cnt_q <= '0;
          end else if (rpt_cnt_q != '1) begin
            rpt_cnt_q <= rpt_cnt_q + RPT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`else
  logic unused_rpt_cfg;
  assign unused_rpt_cfg = ^{REPEAT_DELAY, REPEAT_RATE};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (level_q) begin
            state_q <= PRESS;
            pulse_q <= 1'b1;
          end
        end
        PRESS: begin
          if (!level_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`endif

  assign level_o = level_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/pb_pulse_conditioner.sv
// Up/down pushbutton conditioner feeding the set-value counter.
// Define AUTO_REPEAT_EN to enable hold-to-repeat pulses.
module pb_pulse_conditioner
  import pb_pkg::*;
#(
  parameter logic [DB_W-1:0]  DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [RPT_W-1:0] REPEAT_DELAY    = 24'd5000000,
  parameter logic [RPT_W-1:0] REPEAT_RATE     = 24'd1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up_raw,
  input  logic btn_down_raw,
  output logic PB_up,
  output logic PB_down,
  output logic up_level,
  output logic down_level
);

  logic up_lvl, up_pulse, dn_lvl, dn_pulse;
  logic pb_up_q, pb_down_q, up_level_q, down_level_q;
  logic conflict;

  pb_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_RATE     (REPEAT_RATE)
  ) u_up (
    .clk     (clk),
    .rst_n   (reset),
    .raw_i   (btn_up_raw),
    .level_o (up_lvl),
    .pulse_o (up_pulse)
  );

  pb_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_RATE     (REPEAT_RATE)
  ) u_down (
    .clk     (clk),
    .rst_n   (reset),
    .raw_i   (btn_down_raw),
    .level_o (dn_lvl),
    .pulse_o (dn_pulse)
  );

  // Channel levels here equal the registered level outputs one cycle later,
  // i.e. in the same cycle the gated pulse appears on PB_up/PB_down.
  assign conflict = up_lvl & dn_lvl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pb_up_q      <= 1'b0;
      pb_down_q    <= 1'b0;
      up_level_q   <= 1'b0;
      down_level_q <= 1'b0;
    end else begin
      pb_up_q      <= up_pulse & ~conflict;
      pb_down_q    <= dn_pulse & ~conflict;
      up_level_q   <= up_lvl;
      down_level_q <= dn_lvl;
    end
  end

  assign PB_up      = pb_up_q;
  assign PB_down    = pb_down_q;
  assign up_level   = up_level_q;
  assign down_level = down_level_q;

endmodule
